// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants (also used by decode and the hazard unit).
package fetch_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC   = 64'd0;
  localparam int unsigned     DEFAULT_PC_STEP    = 4;
  localparam int unsigned     DEFAULT_IMEM_BYTES = 76;

  typedef enum logic {RUN, HALT} fetch_state_t;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            valid;
  } if_id_t;

  // A redirect target is fetchable only if word aligned and inside the image
  function automatic logic target_ok(input logic [XLEN-1:0] tgt,
                                     input logic [XLEN-1:0] last_pc);
    return (tgt[1:0] == 2'b00) && (tgt <= last_pc);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, hold, or flush to a bubble.
// Ports:
//   clk, reset : clock, async active-high reset
//   load       : capture d
//   flush      : replace contents with {0, NOP, valid=0}; wins over load
//   d / q      : incoming / held {pc, instr, valid}
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  localparam if_id_t BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

  if_id_t data_d;
  if_id_t data_q;

  // Next contents: flush beats load, otherwise hold
  always_comb begin
    data_d = data_q;
    if (flush) begin
      data_d = BUBBLE;
    end else if (load) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= BUBBLE;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, addresses the zero-latency instruction memory and
// fills the IF/ID register. Handles stall, branch redirect/flush and halts at
// end of image or on an illegal redirect target.
// Ports:
//   clk, reset        : clock, async active-high reset
//   stall             : hold PC and IF/ID
//   branch_taken/target : redirect fetch and flush IF/ID
//   imem_addr / imem_instr : memory address (= PC) and combinational read data
//   if_id_pc/instr/valid   : IF/ID register contents
//   halted, fetch_fault    : fetch stopped; stopped due to a bad redirect (sticky)
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_BYTES = DEFAULT_IMEM_BYTES,
  parameter int unsigned PC_STEP    = DEFAULT_PC_STEP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic        fetch_fault
);

  localparam logic [XLEN-1:0] LAST_PC = XLEN'(IMEM_BYTES - 4);
  localparam logic [XLEN-1:0] STEP    = XLEN'(PC_STEP);

  fetch_state_t    state_d, state_q;
  logic [XLEN-1:0] pc_d, pc_q;
  logic            fault_d, fault_q;
  logic            ifid_load, ifid_flush;
  if_id_t          ifid_in, ifid_out;

  // Next-PC mux, FSM and IF/ID control
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_in    = '{pc: pc_q, instr: imem_instr, valid: 1'b1};

    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          ifid_flush = 1'b1;
          // An illegal target is never placed on imem_addr: PC keeps its value
          if (target_ok(branch_target, LAST_PC)) begin
            pc_d = branch_target;
          end else begin
            state_d = HALT;
            fault_d = 1'b1;
          end
        end else if (!stall) begin
          ifid_load = 1'b1;
          if (pc_q == LAST_PC) begin
            state_d = HALT;
          end else begin
            pc_d = pc_q + STEP;
          end
        end
      end
      HALT: begin
        // Drain the pipeline with bubbles; redirects are ignored
        ifid_flush = !stall;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .reset (reset),
    .load  (ifid_load),
    .flush (ifid_flush),
    .d     (ifid_in),
    .q     (ifid_out)
  );

  assign imem_addr   = pc_q;
  assign if_id_pc    = ifid_out.pc;
  assign if_id_instr = ifid_out.instr;
  assign if_id_valid = ifid_out.valid;
  assign halted      = (state_q == HALT);
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios with literal expectations
// followed by randomized stall/branch/reset traffic checked every cycle
// against a behavioural model of the fetch stage.
module tb_instruction_fetch_unit;

  localparam int unsigned WORDS   = 19;
  localparam logic [63:0] LASTPC  = 64'd72;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        halted;
  logic        fetch_fault;

  instruction_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .halted        (halted),
    .fetch_fault   (fetch_fault)
  );

  always #5 clk = ~clk;

  // Instruction memory image
  logic [31:0] mem [WORDS];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [4:0] idx;
    idx = a[6:2];
    if (a < 64'd76) return mem[idx];
    return 32'hDEAD_BEEF;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  // Behavioural model state
  logic [63:0] m_pc;
  logic [63:0] m_ifpc;
  logic [31:0] m_ifinstr;
  logic        m_valid;
  logic        m_halt;
  logic        m_fault;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 64'd0; m_ifpc = 64'd0; m_ifinstr = NOP; m_valid = 1'b0;
    m_halt = 1'b0; m_fault = 1'b0;
  endtask

  task automatic model_bubble();
    m_ifpc = 64'd0; m_ifinstr = NOP; m_valid = 1'b0;
  endtask

  // One clock edge of the fetch stage, described from the rules
  task automatic model_step();
    if (m_halt) begin
      if (!stall) model_bubble();
    end else if (branch_taken) begin
      model_bubble();
      if (branch_target % 64'd4 != 64'd0 || branch_target > LASTPC) begin
        m_halt = 1'b1; m_fault = 1'b1;
      end else begin
        m_pc = branch_target;
      end
    end else if (!stall) begin
      m_ifpc = m_pc; m_ifinstr = mem[m_pc / 64'd4]; m_valid = 1'b1;
      if (m_pc == LASTPC) m_halt = 1'b1;
      else m_pc = m_pc + 64'd4;
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("imem_addr",   imem_addr,            m_pc);
      check("if_id_pc",    if_id_pc,             m_ifpc);
      check("if_id_instr", 64'(if_id_instr),     64'(m_ifinstr));
      check("if_id_valid", 64'(if_id_valid),     64'(m_valid));
      check("halted",      64'(halted),          64'(m_halt));
      check("fetch_fault", 64'(fetch_fault),     64'(m_fault));
    end
  end

  // Called at posedge+1: drive inputs, take one edge, step the model
  task automatic do_cycle(input logic st, input logic br, input logic [63:0] tgt);
    stall = st; branch_taken = br; branch_target = tgt;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; branch_target = 64'd0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    release_reset();
  endtask

  function automatic logic [63:0] rand_target();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 6)  return 64'($urandom_range(0, 18)) * 64'd4;
    if (r == 6) return 64'($urandom_range(0, 18)) * 64'd4 + 64'($urandom_range(1, 3));
    if (r == 7) return 64'd76;
    if (r == 8) return 64'hFFFF_FFFF_FFFF_FFFC;
    return 64'd80 + 64'($urandom_range(0, 100)) * 64'd4;
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 64'd0;
    for (int i = 0; i < int'(WORDS); i++) mem[i] = $urandom();
    mem[0] = 32'h0030_0593;
    mem[1] = 32'h0140_0513;
    model_reset();
    #1 cmp_en = 1'b1;

    // Reset state
    #11;
    check("rst imem_addr", imem_addr, 64'd0);
    check("rst valid", 64'(if_id_valid), 64'd0);
    check("rst instr", 64'(if_id_instr), 64'(NOP));
    check("rst halted", 64'(halted), 64'd0);
    release_reset();

    // Sequential fetch, 1-cycle latency into IF/ID
    do_cycle(1'b0, 1'b0, 64'd0);
    check("t1 pc0", if_id_pc, 64'd0);
    check("t1 instr0", 64'(if_id_instr), 64'h0030_0593);
    check("t1 valid", 64'(if_id_valid), 64'd1);
    check("t1 addr4", imem_addr, 64'd4);
    do_cycle(1'b0, 1'b0, 64'd0);
    check("t1 pc4", if_id_pc, 64'd4);
    check("t1 instr4", 64'(if_id_instr), 64'h0140_0513);
    check("t1 addr8", imem_addr, 64'd8);

    // Stall three cycles at pc=8
    repeat (3) do_cycle(1'b1, 1'b0, 64'd0);
    check("t2 addr held", imem_addr, 64'd8);
    check("t2 ifid held", if_id_pc, 64'd4);
    do_cycle(1'b0, 1'b0, 64'd0);
    check("t2 addr12", imem_addr, 64'd12);

    // Branch with concurrent stall at pc=16
    do_cycle(1'b0, 1'b0, 64'd0);
    check("t3 addr16", imem_addr, 64'd16);
    do_cycle(1'b1, 1'b1, 64'h20);
    check("t3 addr20", imem_addr, 64'h20);
    check("t3 valid0", 64'(if_id_valid), 64'd0);
    check("t3 nop", 64'(if_id_instr), 64'(NOP));
    do_cycle(1'b0, 1'b0, 64'd0);
    check("t3 instr@20", 64'(if_id_instr), 64'(mem[8]));
    check("t3 pc@20", if_id_pc, 64'h20);

    // Run to the end of the image with random stalls
    for (int i = 0; i < 200; i++) begin
      do_cycle(1'($urandom_range(0, 3) == 0), 1'b0, 64'd0);
      if (halted) break;
    end
    check("t4 halted", 64'(halted), 64'd1);
    check("t4 last pc", if_id_pc, 64'd72);
    check("t4 last valid", 64'(if_id_valid), 64'd1);
    check("t4 addr72", imem_addr, 64'd72);
    do_cycle(1'b0, 1'b1, 64'd0);
    check("t4 drained", 64'(if_id_valid), 64'd0);
    check("t4 addr frozen", imem_addr, 64'd72);

    // Misaligned redirect target
    apply_reset();
    repeat (3) do_cycle(1'b0, 1'b0, 64'd0);
    do_cycle(1'b0, 1'b1, 64'h22);
    check("t5 halted", 64'(halted), 64'd1);
    check("t5 fault", 64'(fetch_fault), 64'd1);
    check("t5 addr kept", imem_addr, 64'd12);
    check("t5 valid0", 64'(if_id_valid), 64'd0);
    do_cycle(1'b0, 1'b0, 64'd0);
    check("t5 fault sticky", 64'(fetch_fault), 64'd1);

    // Out-of-range redirect target
    apply_reset();
    repeat (2) do_cycle(1'b0, 1'b0, 64'd0);
    do_cycle(1'b0, 1'b1, 64'h100);
    check("t5b halted", 64'(halted), 64'd1);
    check("t5b fault", 64'(fetch_fault), 64'd1);
    check("t5b addr kept", imem_addr, 64'd8);

    // Asynchronous reset between edges at pc=40
    apply_reset();
    repeat (10) do_cycle(1'b0, 1'b0, 64'd0);
    check("t6 addr40", imem_addr, 64'd40);
    #1 reset = 1'b1;
    model_reset();
    #1;
    check("t6 async addr", imem_addr, 64'd0);
    check("t6 async valid", 64'(if_id_valid), 64'd0);
    check("t6 async pc", if_id_pc, 64'd0);
    check("t6 async instr", 64'(if_id_instr), 64'(NOP));
    release_reset();
    do_cycle(1'b0, 1'b0, 64'd0);
    check("t6 restart pc", if_id_pc, 64'd0);
    check("t6 restart instr", 64'(if_id_instr), 64'h0030_0593);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0) begin
        apply_reset();
      end else begin
        do_cycle(1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 9) == 0),
                 rand_target());
      end
    end

    @(negedge clk);
    #1 cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
